axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
Round-robin, packet-granular arbiter that shares one AXI-Stream master port between NUM_SRC stream sources, each typically a power-of-3 sequence generator. It locks a grant for a whole packet and releases it on the accepted last beat. A per-grant beat cap forces packet termination, because sources may not drive tlast reliably. The output passes through a one-deep registered slice in front of the downstream sink.

Parameters:
DATA_SIZE, 32, tdata width in bits (multiple of 8)
NUM_SRC, 4, number of requesting sources (2..8)
MAX_BEATS, 16, beat cap per grant; 0 disables the cap

Ports:
axis_aclk  in  1  single clock; all logic on rising edge
axis_areset  in  1  asynchronous, active-high reset
s_axis_tdata  in  NUM_SRC*DATA_SIZE  source data; source i occupies bits [i*DATA_SIZE +: DATA_SIZE]
s_axis_tstrb  in  NUM_SRC*DATA_SIZE/8  source byte strobes, packed the same way
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tlast  in  NUM_SRC  per-source last
s_axis_tready  out  NUM_SRC  per-source ready
m00_axis_tdata  out  DATA_SIZE  arbitrated data (registered)
m00_axis_tstrb  out  DATA_SIZE/8  arbitrated strobes (registered)
m00_axis_tvalid  out  1  output valid (registered)
m00_axis_tlast  out  1  output last (registered; source last OR cap reached)
m00_axis_tready  in  1  downstream ready
grant  out  NUM_SRC  one-hot current grant; 0 when idle
busy  out  1  high while a grant is locked

Behaviour:
- Reset (async, active-high): state=IDLE; grant=0; busy=0; m00_axis_tvalid=0; tdata/tstrb/tlast=0; s_axis_tready=0; beat_cnt=0; the rr pointer is set so that source 0 has top priority first.
- State IDLE:
  - If any s_axis_tvalid is high, select the first requester at or after the rr pointer, wrapping modulo NUM_SRC.
  - Next cycle: state=LOCKED, grant=one-hot(sel), busy=1, beat_cnt=0.
  - rr pointer = sel+1 (mod NUM_SRC), so the winner gets lowest priority next round.
  - No requester: remain in IDLE.
- State LOCKED:
  - load = !m00_axis_tvalid || m00_axis_tready.
  - s_axis_tready[g] = load for the granted g; all other readies are 0.
  - Accepted beat = s_axis_tvalid[g] && s_axis_tready[g]. On an accepted beat the output slice registers tdata/tstrb, sets tvalid=1 and increments beat_cnt.
  - Registered tlast = s_axis_tlast[g] || (MAX_BEATS!=0 && beat_cnt==MAX_BEATS-1).
  - An accepted beat with computed tlast=1 releases the grant: next cycle state=IDLE, grant=0, busy=0.
- Output slice: if load and no beat is accepted, tvalid goes to 0. While tvalid=1 and m00_axis_tready=0, all m00 outputs hold stable and the upstream ready is 0. Full throughput is one beat per cycle when the sink is always ready.
- Latency: source beat to m00 output is 1 cycle. Request to grant is 1 cycle. The first beat is accepted in the first LOCKED cycle. The grant is not released until the final beat is accepted upstream; the slice may still hold that beat after release.
- Packet gap: at least one IDLE cycle between packets, including from the same source. A new grant may lock while the slice still holds the prior last beat; that beat is not lost, because load stays 0 until the sink accepts it.
- Granted source drops tvalid mid-packet: the grant is held. There is no timeout, and other requesters wait.
- Cap: beat_cnt never exceeds MAX_BEATS-1. A source that continues after a forced last must re-arbitrate, and its next beat starts a new packet.
- MAX_BEATS=1: every beat is a one-beat packet with tlast=1.
- Requesters appearing during LOCKED are ignored until IDLE. Simultaneous requests are resolved purely by the rr pointer.
- Reset mid-packet: outputs clear immediately (async). A partial packet is dropped with no tlast emitted.
- beat_cnt width is clog2(MAX_BEATS+1), minimum 1 bit.

Test Plan:
- Reset then src0 only, 4 beats 1,3,9,27 with tlast on 27, sink ready → m00 shows 1,3,9,27 at 1-cycle latency; tlast on 27; grant=0001 then 0; busy falls the cycle after 27 is accepted.
- src0..3 all valid continuously, 2-beat packets → grant order 0,1,2,3,0; exactly 2 beats per grant; one idle cycle between grants.
- MAX_BEATS=16, src1 streams without tlast → tlast forced on beat 16 (value 3^15=14348907); src1 re-grants only after the other requesters are served.
- Sink ready toggles 1,0,0,1 during a packet → m00 data held stable while ready=0; no beat duplicated or lost; s_axis_tready low while the slice is full.
- Granted src2 drops tvalid for 3 cycles mid-packet while src3 requests → grant stays 0100; no src3 beats appear until src2's tlast is accepted.
- Assert axis_areset for 1 cycle mid-packet → same cycle: m00_axis_tvalid=0, grant=0, busy=0; after release, src0 wins first if it is requesting.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter
//   Round-robin, packet-granular arbiter sharing one AXI-Stream master port
//   between NUM_SRC sources. A grant is locked for a whole packet and released
//   on the accepted last beat (source tlast, or the per-grant beat cap when
//   MAX_BEATS != 0). The output is a one-deep registered slice.
//
// Ports
//   axis_aclk        clock, rising edge
//   axis_areset      asynchronous active-high reset
//   s_axis_tdata     NUM_SRC packed source data, source i at [i*DATA_SIZE +: DATA_SIZE]
//   s_axis_tstrb     NUM_SRC packed source strobes, same packing
//   s_axis_tvalid    per-source valid
//   s_axis_tlast     per-source last
//   s_axis_tready    per-source ready (only the granted source can see ready)
//   m00_axis_*       registered arbitrated output stream
//   m00_axis_tready  downstream ready
//   grant            one-hot current grant, 0 when idle
//   busy             high while a grant is locked
module axis_rr_packet_arbiter #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic                             axis_aclk,
   input  logic                             axis_areset,
   input  logic [NUM_SRC*DATA_SIZE-1:0]     s_axis_tdata,
   input  logic [NUM_SRC*DATA_SIZE/8-1:0]   s_axis_tstrb,
   input  logic [NUM_SRC-1:0]               s_axis_tvalid,
   input  logic [NUM_SRC-1:0]               s_axis_tlast,
   output logic [NUM_SRC-1:0]               s_axis_tready,
   output logic [DATA_SIZE-1:0]             m00_axis_tdata,
   output logic [DATA_SIZE/8-1:0]           m00_axis_tstrb,
   output logic                             m00_axis_tvalid,
   output logic                             m00_axis_tlast,
   input  logic                             m00_axis_tready,
   output logic [NUM_SRC-1:0]               grant,
   output logic                             busy
);

   localparam int unsigned STRB_SIZE = DATA_SIZE / 8;
   localparam int unsigned PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned CNT_W     = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
   localparam int unsigned CAP_LAST  = (MAX_BEATS == 0) ? 0 : MAX_BEATS - 1;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t                 state_q,    state_d;
   logic [NUM_SRC-1:0]     grant_q,    grant_d;
   logic [PTR_W-1:0]       gidx_q,     gidx_d;
   logic [PTR_W-1:0]       rr_ptr_q,   rr_ptr_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [DATA_SIZE-1:0]   tdata_q,    tdata_d;
   logic [STRB_SIZE-1:0]   tstrb_q,    tstrb_d;
   logic                   tvalid_q,   tvalid_d;
   logic                   tlast_q,    tlast_d;

   logic                   locked;
   logic                   load;
   logic                   accept;
   logic                   cap_hit;
   logic                   beat_last;
   logic                   found;
   logic [PTR_W-1:0]       sel;
   logic [PTR_W-1:0]       sel_nxt;

   // The slice can take a new beat when empty or when its beat leaves this cycle.
   assign locked    = (state_q == ST_LOCKED);
   assign load      = !tvalid_q || m00_axis_tready;
   assign accept    = locked && s_axis_tvalid[gidx_q] && load;
   assign cap_hit   = (MAX_BEATS != 0) && (beat_cnt_q == CNT_W'(CAP_LAST));
   assign beat_last = s_axis_tlast[gidx_q] || cap_hit;

   assign s_axis_tready   = grant_q & {NUM_SRC{locked && load}};
   assign m00_axis_tdata  = tdata_q;
   assign m00_axis_tstrb  = tstrb_q;
   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tlast  = tlast_q;
   assign grant           = grant_q;
   assign busy            = locked;

   // First requester at or after the rr pointer, wrapping modulo NUM_SRC.
   always_comb begin
      int unsigned idx;
      int unsigned nxt;
      idx     = 0;
      nxt     = 0;
      found   = 1'b0;
      sel     = rr_ptr_q;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_SRC;
         if (!found && s_axis_tvalid[idx]) begin
            found = 1'b1;
            sel   = PTR_W'(idx);
         end
      end
      nxt     = (int'(sel) + 1) % NUM_SRC;
      sel_nxt = PTR_W'(nxt);
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      tdata_d    = tdata_q;
      tstrb_d    = tstrb_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d    = ST_LOCKED;
               grant_d    = NUM_SRC'(1) << sel;
               gidx_d     = sel;
               rr_ptr_d   = sel_nxt;
               beat_cnt_d = '0;
            end
         end
         ST_LOCKED: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_last) begin
                  state_d    = ST_IDLE;
                  grant_d    = '0;
                  beat_cnt_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Output slice: in IDLE accept is 0, so a held beat simply drains.
      if (load) begin
         tvalid_d = accept;
         if (accept) begin
            tdata_d = s_axis_tdata[gidx_q*DATA_SIZE +: DATA_SIZE];
            tstrb_d = s_axis_tstrb[gidx_q*STRB_SIZE +: STRB_SIZE];
            tlast_d = beat_last;
         end
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         tdata_q    <= '0;
         tstrb_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         tdata_q    <= tdata_d;
         tstrb_q    <= tstrb_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
      end
   end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Self-checking bench for axis_rr_packet_arbiter: randomized power-of-3 sources
// compared cycle by cycle against a transaction-level reference model.
module tb_axis_rr_packet_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;
   localparam int unsigned MB = 16;
   localparam int unsigned SW = DW / 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NS*DW-1:0]     s_tdata;
   logic [NS*SW-1:0]     s_tstrb;
   logic [NS-1:0]        s_tvalid;
   logic [NS-1:0]        s_tlast;
   logic [NS-1:0]        s_tready;
   logic [DW-1:0]        m_tdata;
   logic [SW-1:0]        m_tstrb;
   logic                 m_tvalid;
   logic                 m_tlast;
   logic                 m_tready;
   logic [NS-1:0]        grant;
   logic                 busy;

   always #5 clk = ~clk;

   axis_rr_packet_arbiter #(
      .DATA_SIZE (DW),
      .NUM_SRC   (NS),
      .MAX_BEATS (MB)
   ) dut (
      .axis_aclk       (clk),
      .axis_areset     (rst),
      .s_axis_tdata    (s_tdata),
      .s_axis_tstrb    (s_tstrb),
      .s_axis_tvalid   (s_tvalid),
      .s_axis_tlast    (s_tlast),
      .s_axis_tready   (s_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready),
      .grant           (grant),
      .busy            (busy)
   );

   // Source generators: each source emits 1, 3, 9, 27, ... advancing on acceptance.
   logic [DW-1:0]  src_val  [NS];
   logic [SW-1:0]  src_strb [NS];
   int             src_beat [NS];
   logic [NS-1:0]  src_v;
   logic [NS-1:0]  src_l;
   int             ph;

   always_comb begin
      s_tdata  = '0;
      s_tstrb  = '0;
      for (int i = 0; i < NS; i++) begin
         s_tdata[i*DW +: DW] = src_val[i];
         s_tstrb[i*SW +: SW] = src_strb[i];
      end
      s_tvalid = src_v;
      s_tlast  = src_l;
   end

   // Reference model state: owner is -1 when idle.
   int             m_owner, m_ptr, m_cnt;
   bit             m_ov, m_ol;
   logic [DW-1:0]  m_od;
   logic [SW-1:0]  m_os;
   logic [NS-1:0]  acc_vec;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_ov    = 0;
      m_ol    = 0;
      m_od    = '0;
      m_os    = '0;
   endtask

   task automatic drive_sources(input logic [NS-1:0] acc);
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) begin
            src_val[i]  = src_val[i] * 3;
            src_beat[i] = src_beat[i] + 1;
            src_v[i]    = 1'b0;
         end else if (src_v[i] && ph == 3 && $urandom_range(0, 9) == 0) begin
            src_v[i] = 1'b0;
         end
         if (!src_v[i]) begin
            case (ph)
               0: begin
                  src_v[i] = (i == 0) && (src_beat[i] < 4);
                  src_l[i] = (src_beat[i] % 4) == 3;
               end
               1: begin
                  src_v[i] = 1'b1;
                  src_l[i] = (src_beat[i] % 2) == 1;
               end
               2: begin
                  src_v[i] = 1'b1;
                  src_l[i] = (i != 1) && ((src_beat[i] % 2) == 1);
               end
               default: begin
                  src_v[i] = $urandom_range(0, 99) < 60;
                  src_l[i] = $urandom_range(0, 3) == 0;
               end
            endcase
            src_strb[i] = SW'($urandom);
         end
      end
   endtask

   task automatic run_phase(input int phase, input int ncyc, input int rst_at);
      bit             ld, ac, lst, post_rst;
      logic [NS-1:0]  exp_rdy, exp_gnt;
      int             n_owner, n_ptr, n_cnt, j;
      bit             n_ov, n_ol;
      logic [DW-1:0]  n_od;
      logic [SW-1:0]  n_os;
      ph       = phase;
      post_rst = 0;
      for (int c = 0; c < ncyc; c++) begin
         // posedge + 1: drive inputs
         drive_sources(acc_vec);
         if (post_rst) begin
            src_v[0] = 1'b1;
            post_rst = 0;
         end
         m_tready = (ph < 3) ? 1'b1 : ($urandom_range(0, 99) < 60);

         ld      = !m_ov || m_tready;
         ac      = (m_owner >= 0) && src_v[m_owner] && ld;
         exp_gnt = (m_owner >= 0) ? (NS'(1) << m_owner) : '0;
         exp_rdy = (m_owner >= 0 && ld) ? exp_gnt : '0;

         @(negedge clk);
         check_eq("grant", grant, exp_gnt);
         check_eq("busy", busy, m_owner >= 0);
         check_eq("s_tready", s_tready, exp_rdy);
         check_eq("m_tvalid", m_tvalid, m_ov);
         if (m_ov) begin
            check_eq("m_tdata", m_tdata, m_od);
            check_eq("m_tstrb", m_tstrb, m_os);
            check_eq("m_tlast", m_tlast, m_ol);
         end

         if (c == rst_at) begin
            #1 rst = 1'b1;
            #1;
            check_eq("rst_tvalid", m_tvalid, 0);
            check_eq("rst_grant", grant, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_tready", s_tready, 0);
            model_reset();
            @(posedge clk);
            #1 rst = 1'b0;
            acc_vec  = '0;
            post_rst = 1;
            continue;
         end

         n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
         n_ov = m_ov; n_ol = m_ol; n_od = m_od; n_os = m_os;
         lst = 0;
         if (m_owner < 0) begin
            for (int k = NS - 1; k >= 0; k--) begin
               j = (m_ptr + k) % NS;
               if (src_v[j]) begin
                  n_owner = j;
                  n_ptr   = (j + 1) % NS;
                  n_cnt   = 0;
               end
            end
         end else if (ac) begin
            lst   = src_l[m_owner] || (MB != 0 && m_cnt == MB - 1);
            n_cnt = m_cnt + 1;
            if (lst) begin
               n_owner = -1;
               n_cnt   = 0;
            end
         end
         if (ld) begin
            n_ov = ac;
            if (ac) begin
               n_od = src_val[m_owner];
               n_os = src_strb[m_owner];
               n_ol = lst;
            end
         end
         acc_vec = ac ? exp_gnt : '0;

         @(posedge clk);
         #1;
         m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
         m_ov = n_ov; m_ol = n_ol; m_od = n_od; m_os = n_os;
      end
   endtask

   initial begin
      rst      = 1'b1;
      m_tready = 1'b0;
      src_v    = '0;
      src_l    = '0;
      ph       = 0;
      acc_vec  = '0;
      for (int i = 0; i < NS; i++) begin
         src_val[i]  = 1;
         src_strb[i] = '1;
         src_beat[i] = 0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_tvalid", m_tvalid, 0);
      check_eq("reset_tdata", m_tdata, 0);
      check_eq("reset_tlast", m_tlast, 0);
      check_eq("reset_grant", grant, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_tready", s_tready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_phase(0, 12, -1);     // src0 alone: 1,3,9,27 with tlast on 27
      for (int i = 0; i < NS; i++) src_beat[i] = 0;
      run_phase(1, 40, -1);     // all sources, 2-beat packets
      src_val[1] = 1;
      run_phase(2, 120, -1);    // src1 never asserts tlast: cap forces it
      run_phase(3, 1500, 700);  // random traffic, sink stalls, drops, mid-run reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
